// File: rtl/fifo_rdport_ctrl.sv
// FIFO controller owning both ports of a 1rw1rw RAM; prefetch buffer gives FWFT output.
// Latency: write to out_valid is 2+L cycles (L = RAM read latency, 1 or 2).
// Backpressure: in_ready drops only when the RAM is full; reads are credit-gated by prefetch space.
module fifo_rdport_ctrl #(
  parameter int    WIDTH_DATA = 8,
  parameter int    WIDTH_ADDR = 8,
  parameter string DOUT_REG   = "false"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH_DATA-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH_DATA-1:0] out_data,
  input  logic                  out_ready,
  output logic [WIDTH_ADDR+1:0] count,
  output logic [WIDTH_ADDR-1:0] mem_addra,
  output logic [WIDTH_DATA-1:0] mem_dina,
  output logic                  mem_wena,
  output logic                  mem_rena,
  output logic [WIDTH_ADDR-1:0] mem_addrb,
  output logic                  mem_renb,
  output logic                  mem_wenb,
  output logic [WIDTH_DATA-1:0] mem_dinb,
  input  logic [WIDTH_DATA-1:0] mem_doutb
);

  localparam int LAT      = (DOUT_REG == "true") ? 2 : 1;
  localparam int OB_DEPTH = LAT + 2;
  localparam int CW       = WIDTH_ADDR + 2;
  localparam logic [WIDTH_ADDR:0] RAM_DEPTH = {1'b1, {WIDTH_ADDR{1'b0}}};

  logic [WIDTH_ADDR-1:0] wptr;
  logic [WIDTH_ADDR-1:0] rptr;
  logic [WIDTH_ADDR:0]   ram_cnt;
  logic [LAT-1:0]        rd_sr;     // one bit per outstanding RAM read
  logic [1:0]            inflight;
  logic [2:0]            ob_cnt;
  logic [1:0]            ob_head;
  logic [1:0]            ob_tail;
  // Sized to 4 so a 2-bit index never leaves the array; only OB_DEPTH slots are used.
  logic [WIDTH_DATA-1:0] ob_mem [4];

  logic wr;
  logic issue;
  logic capture;
  logic pop;

  // Circular index advance over the OB_DEPTH used slots.
  function automatic logic [1:0] ob_next(input logic [1:0] idx);
    return (idx == 2'(OB_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

  assign in_ready  = !rst && (ram_cnt < RAM_DEPTH);
  assign wr        = in_valid && in_ready;

  // Credit check uses only registered state, so no path from out_ready or in_valid.
  assign issue     = !rst && (ram_cnt != '0) &&
                     (({1'b0, ob_cnt} + {2'b00, inflight}) < 4'(OB_DEPTH));
  assign capture   = rd_sr[LAT-1];

  assign out_valid = !rst && (ob_cnt != 3'd0);
  assign out_data  = ob_mem[ob_head];
  assign pop       = out_valid && out_ready;

  assign mem_wena  = wr;
  assign mem_addra = wptr;
  assign mem_dina  = in_data;
  assign mem_rena  = 1'b0;
  assign mem_renb  = issue;
  assign mem_addrb = rptr;
  assign mem_wenb  = 1'b0;
  assign mem_dinb  = '0;

  assign count = rst ? '0 : (CW'(ram_cnt) + CW'(inflight) + CW'(ob_cnt));

  // Pointer, occupancy and read-tracking state; reset drops everything including in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      rd_sr    <= '0;
      inflight <= '0;
      ob_cnt   <= '0;
      ob_head  <= '0;
      ob_tail  <= '0;
    end else begin
      if (wr)      wptr    <= wptr + 1'b1;
      if (issue)   rptr    <= rptr + 1'b1;
      if (capture) ob_tail <= ob_next(ob_tail);
      if (pop)     ob_head <= ob_next(ob_head);
      ram_cnt  <= ram_cnt + (WIDTH_ADDR+1)'(wr) - (WIDTH_ADDR+1)'(issue);
      rd_sr    <= LAT'({rd_sr, issue});
      inflight <= inflight + 2'(issue) - 2'(capture);
      ob_cnt   <= ob_cnt + 3'(capture) - 3'(pop);
    end
  end

  // Prefetch storage holds data only; stale slots are never visible because ob_cnt gates them.
  always_ff @(posedge clk) begin
    if (!rst && capture) ob_mem[ob_tail] <= mem_doutb;
  end

endmodule

// File: tb/tb_fifo_rdport_ctrl.sv
// Bench for fifo_rdport_ctrl: instance A (WIDTH_ADDR=4, L=1) and instance B (WIDTH_ADDR=3, L=2),
// each with a behavioural RAM; a queue scoreboard predicts data order and count.
// Only the selected instance is exercised; the other is held in reset.
module tb_fifo_rdport_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  always #5 clk = ~clk;

  // Instance A signals
  logic       in_ready_a, out_valid_a, mem_wena_a, mem_rena_a, mem_renb_a, mem_wenb_a;
  logic [7:0] out_data_a, mem_dina_a, mem_dinb_a, mem_doutb_a;
  logic [5:0] count_a;
  logic [3:0] mem_addra_a, mem_addrb_a;
  // Instance B signals
  logic       in_ready_b, out_valid_b, mem_wena_b, mem_rena_b, mem_renb_b, mem_wenb_b;
  logic [7:0] out_data_b, mem_dina_b, mem_dinb_b, mem_doutb_b, r1_b;
  logic [4:0] count_b;
  logic [2:0] mem_addra_b, mem_addrb_b;

  wire rst_a = sel ? 1'b1 : rst;
  wire rst_b = sel ? rst : 1'b1;

  fifo_rdport_ctrl #(.WIDTH_DATA(8), .WIDTH_ADDR(4), .DOUT_REG("false")) u_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid & ~sel), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready & ~sel), .count(count_a),
    .mem_addra(mem_addra_a), .mem_dina(mem_dina_a), .mem_wena(mem_wena_a), .mem_rena(mem_rena_a),
    .mem_addrb(mem_addrb_a), .mem_renb(mem_renb_a), .mem_wenb(mem_wenb_a), .mem_dinb(mem_dinb_a),
    .mem_doutb(mem_doutb_a));

  fifo_rdport_ctrl #(.WIDTH_DATA(8), .WIDTH_ADDR(3), .DOUT_REG("true")) u_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid & sel), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready & sel), .count(count_b),
    .mem_addra(mem_addra_b), .mem_dina(mem_dina_b), .mem_wena(mem_wena_b), .mem_rena(mem_rena_b),
    .mem_addrb(mem_addrb_b), .mem_renb(mem_renb_b), .mem_wenb(mem_wenb_b), .mem_dinb(mem_dinb_b),
    .mem_doutb(mem_doutb_b));

  // RAM models: A has one read register stage, B has an extra output register.
  logic [7:0] ram_a [16];
  logic [7:0] ram_b [8];
  always @(posedge clk) begin
    if (mem_wena_a) ram_a[mem_addra_a] <= mem_dina_a;
    if (mem_renb_a) mem_doutb_a <= ram_a[mem_addrb_a];
  end
  always @(posedge clk) begin
    if (mem_wena_b) ram_b[mem_addra_b] <= mem_dina_b;
    if (mem_renb_b) r1_b <= ram_b[mem_addrb_b];
    mem_doutb_b <= r1_b;
  end

  // Selected-instance view
  wire       in_ready  = sel ? in_ready_b  : in_ready_a;
  wire       out_valid = sel ? out_valid_b : out_valid_a;
  wire [7:0] out_data  = sel ? out_data_b  : out_data_a;
  wire [5:0] count     = sel ? {1'b0, count_b} : count_a;
  wire       mem_wena  = sel ? mem_wena_b  : mem_wena_a;
  wire       mem_renb  = sel ? mem_renb_b  : mem_renb_a;
  wire       mem_rena  = sel ? mem_rena_b  : mem_rena_a;
  wire       mem_wenb  = sel ? mem_wenb_b  : mem_wenb_a;
  wire [7:0] mem_dina  = sel ? mem_dina_b  : mem_dina_a;
  wire [7:0] mem_dinb  = sel ? mem_dinb_b  : mem_dinb_a;
  wire [3:0] mem_addra = sel ? {1'b0, mem_addra_b} : mem_addra_a;
  wire [3:0] mem_addrb = sel ? {1'b0, mem_addrb_b} : mem_addrb_a;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];
  int acc = 0;
  int pops = 0;
  logic       sv_ovalid, sv_irdy;
  logic [7:0] sv_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, score against the queue model, then advance one clock.
  task automatic step();
    #2;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_en", {mem_wena, mem_renb}, 0);
      q.delete();
    end else begin
      chk("count", count, q.size());
      chk("const_ports", {mem_rena, mem_wenb, mem_dinb}, 0);
      if (mem_wena && mem_renb) chk("addr_collision", mem_addra != mem_addrb, 1);
      if (in_valid && in_ready) chk("wr_port", {mem_wena, mem_addra == mem_addra, mem_dina}, {2'b11, in_data});
      else chk("wr_idle", mem_wena, 0);
      if (out_valid) begin
        chk("head_present", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("out_data", out_data, q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            pops++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        acc++;
      end
    end
    sv_ovalid = out_valid;
    sv_irdy   = in_ready;
    sv_data   = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 300 && q.size() > 0; g++) step();
    chk("drain_done", q.size(), 0);
    step();
  endtask

  task automatic single_word(input int lat);
    int first;
    first = -1;
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) in_valid = 1'b0;
      step();
      chk("t1_in_ready", sv_irdy, 1);
      if (sv_ovalid && first < 0) begin
        first = c;
        chk("t1_data", sv_data, 8'hA5);
      end
    end
    chk("t1_latency", first, 2 + lat);
  endtask

  initial begin
    int acc0, pops0, gaps, written;
    bit started;
    logic [7:0] fw;

    // Reset, instance A
    rst = 1'b1; sel = 1'b0;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    single_word(1);

    // Fill with consumer stalled: RAM depth plus prefetch/in-flight slack
    in_valid = 1'b1; out_ready = 1'b0; acc0 = acc;
    for (int c = 0; c < 40; c++) begin
      in_data = 8'($urandom);
      step();
    end
    chk("fill_accepted", acc - acc0, 19);
    chk("fill_in_ready", sv_irdy, 0);
    drain();

    // Reset mid-operation with 10 held and a read in flight
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      in_data = 8'($urandom_range(1, 255));
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    out_ready = 1'b1; step();
    out_ready = 1'b0; step();
    chk("held_before_rst", q.size(), 10);
    rst = 1'b1; step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    fw = 8'h00;
    for (int g = 0; g < 10 && fw == 8'h00; g++) begin
      step();
      if (sv_ovalid) fw = sv_data;
    end
    chk("rst_first_word", fw, 8'h3C);
    drain();

    // Wrap-around with occupancy kept in 10..16
    written = 0;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_data = 8'($urandom);
      step();
      written++;
    end
    for (int g = 0; g < 2000 && written < 40; g++) begin
      in_valid  = (q.size() < 16) && ($urandom_range(1) == 1);
      out_ready = (q.size() > 10) && ($urandom_range(1) == 1);
      in_data   = 8'($urandom);
      acc0 = acc;
      step();
      written += acc - acc0;
    end
    chk("wrap_written", written, 40);
    drain();

    // Switch to instance B (L=2, depth 8)
    rst = 1'b1; sel = 1'b1;
    step(); step();
    rst = 1'b0;
    single_word(2);

    // Streaming 0..99 with no gaps after the first output
    in_valid = 1'b1; out_ready = 1'b1; pops0 = pops; gaps = 0; started = 1'b0;
    for (int c = 0; c < 160 && (pops - pops0) < 100; c++) begin
      if (c < 100) in_data = 8'(c);
      else in_valid = 1'b0;
      step();
      if (sv_ovalid) started = 1'b1;
      else if (started && (pops - pops0) < 100) gaps++;
    end
    chk("stream_popped", pops - pops0, 100);
    chk("stream_gaps", gaps, 0);
    drain();

    // Random backpressure, 2000 words
    pops0 = pops;
    for (int g = 0; g < 20000 && (pops - pops0) < 2000; g++) begin
      in_valid  = $urandom_range(1) == 1;
      out_ready = $urandom_range(1) == 1;
      in_data   = 8'($urandom);
      step();
    end
    chk("rand_popped", (pops - pops0) >= 2000, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rdport_ctrl.md
# fifo_rdport_ctrl

Single-clock FIFO controller that sits directly in front of a `mem_1rw1rw_xilinx` instance and owns both of its ports.

- Port A is the write port. Port B is the read port.
- The controller presents valid/ready streaming interfaces upstream and downstream.
- It hides the RAM read latency behind a small output prefetch buffer, so the consumer sees first-word-fall-through data at up to one word per cycle.
- It is the standard buffering stage in front of TX-path consumers that need deep, RAM-backed queues.

## Interface
Parameters:
- `WIDTH_DATA`, 8: word width; must match the RAM instance.
- `WIDTH_ADDR`, 8: RAM address width; RAM depth is 2^WIDTH_ADDR.
- `DOUT_REG`, "false": must match the RAM's `DOUT_REG_B`. Read latency L = 2 if "true", else 1.

Ports:
- `clk` in 1: single clock; also drives both RAM clocks.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: upstream word valid.
- `in_data` in WIDTH_DATA: upstream word.
- `in_ready` out 1: FIFO can accept a word.
- `out_valid` out 1: head word valid.
- `out_data` out WIDTH_DATA: head word.
- `out_ready` in 1: consumer accepts the head word.
- `count` out WIDTH_ADDR+2: total words held (RAM + in flight + prefetch buffer).
- `mem_addra` out WIDTH_ADDR: RAM port A address.
- `mem_dina` out WIDTH_DATA: RAM port A write data.
- `mem_wena` out 1: RAM port A write enable.
- `mem_rena` out 1: RAM port A read enable; constant 0.
- `mem_addrb` out WIDTH_ADDR: RAM port B address.
- `mem_renb` out 1: RAM port B read enable.
- `mem_wenb` out 1: RAM port B write enable; constant 0.
- `mem_dinb` out WIDTH_DATA: RAM port B write data; constant 0.
- `mem_doutb` in WIDTH_DATA: RAM port B read data.

## Operation
State:
- `wptr` and `rptr`: WIDTH_ADDR bits each; wrap naturally.
- `ram_cnt`: 0..2^WIDTH_ADDR.
- Read-valid shift register: L stages, tracks in-flight reads.
- `inflight`: 0..L.
- Prefetch buffer: D = L+2 entries, a circular FIFO with `ob_cnt`.

Write side:
- `in_ready` = !rst && (ram_cnt < 2^WIDTH_ADDR).
- When `in_valid && in_ready`, the block drives `mem_wena`=1, `mem_addra`=wptr, `mem_dina`=in_data combinationally, and wptr increments.

Read issue:
- `mem_renb` = !rst && ram_cnt>0 && (ob_cnt+inflight) < D, where ob_cnt is the registered value.
- On issue, `mem_addrb`=rptr and rptr increments. A 1 enters the shift register.
- When the shift register output is 1, `mem_doutb` is written into the prefetch buffer that cycle.

Counters:
- `ram_cnt` next = ram_cnt + write − issue. Simultaneous write and issue leave it unchanged.
- `count` = ram_cnt + inflight + ob_cnt, registered. Maximum is 2^WIDTH_ADDR + L + 2.

Output:
- `out_valid` = ob_cnt>0.
- `out_data` = prefetch head.
- A pop occurs on `out_valid && out_ready`.
- A capture and a pop in the same cycle keep ob_cnt unchanged.
- The capture never overflows the buffer, because issue is gated by the credit condition.

Collision freedom:
- An issue only targets addresses whose write committed on an earlier edge.
- A write never targets an unread address.
- Port A and port B addresses are therefore never equal in the same cycle with both enabled. The RAM's READ_DURING_WRITE setting is irrelevant.

Reset:
- wptr, rptr, ram_cnt, inflight, shift register and ob_cnt are cleared to 0.
- `out_valid`=0, `count`=0, `in_ready`=0, and all mem enables are 0 while rst is high.
- Reset asserted mid-operation discards all contents, including in-flight reads. Returning RAM data is ignored because the shift register is cleared.
- RAM contents are not cleared.

## Timing
- Write in cycle 0 into an empty FIFO:
  - ram_cnt=1 in cycle 1, and the read issues in cycle 1.
  - Data is captured at the end of cycle 1+L.
  - `out_valid`=1 in cycle 2+L: cycle 3 for L=1, cycle 4 for L=2.
- `count` reflects a write or pop on the following cycle.
- Sustained throughput is 1 word/cycle in and out once the FIFO holds at least L+2 words.
- `in_ready` has no combinational path from `out_ready`. `mem_renb` has no combinational path from `out_ready` or `in_valid`.
- Full: `in_ready`=0 only when ram_cnt=2^WIDTH_ADDR. A pop that frees RAM space (via an issue) raises `in_ready` one cycle later.
- Pointer wrap from 2^WIDTH_ADDR−1 to 0 is seamless.

## Test plan
- Reset, L=1, WIDTH_ADDR=4:
  - One write of 0xA5 in cycle 0, with out_ready=1.
  - Expect `out_valid` in cycle 3 with out_data=0xA5, `count` back to 0 in cycle 4, and in_ready=1 throughout.
- Fill, out_ready=0, WIDTH_ADDR=4, L=1:
  - Write until in_ready drops.
  - Expect exactly 16+3=19 words accepted, count=19, and in_ready=0 from the cycle after ram_cnt reaches 16.
- Streaming with L=2:
  - 100 consecutive words 0..99, in_valid=1 and out_ready=1 continuously.
  - Expect in-order output with no gaps after the first word.
  - After the first output cycle, out_valid stays high every cycle until word 99.
- Random backpressure:
  - in_valid and out_ready each random at 50%, 2000 words, WIDTH_ADDR=3.
  - Expect order preserved and no data loss or duplication.
  - Check mem_addra≠mem_addrb whenever mem_wena&&mem_renb.
- Reset mid-operation:
  - Assert rst for 1 cycle with 10 words held and a read in flight.
  - Expect count=0 and out_valid=0 the next cycle, no stale word ever presented, and the next written word 0x3C emerging first.
- Wrap-around:
  - 40 words through WIDTH_ADDR=4 with occupancy held between 10 and 16.
  - Expect correct data across two pointer wraps, and count always equal to words written minus words popped.
